// File: rtl/key_expand_seq.sv
// Sequential AES key expansion: one 32-bit word per cycle, round keys streamed out with a valid/ready handshake.
// Optional feature: define KEYEXP_ABORT_EN to add an abort input that cancels a running expansion.
module key_expand_seq #(
  parameter int MAX_NK   = 8,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [255:0]        key_in,
  input  logic                rk_ready,
`ifdef KEYEXP_ABORT_EN
  input  logic                abort,
`endif
  output logic                rk_valid,
  output logic [RK_IDX_W-1:0] rk_idx,
  output logic [127:0]        round_key,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, EXPAND, HOLD} state_t;

  state_t        state, state_nxt;
  logic [255:0]  key_q;
  logic [3:0]    nk_q, nr_q, nk_s, nr_s;
  logic [5:0]    total_q, word_cnt;
  logic [2:0]    mod_cnt;
  logic [7:0]    rcon;
  logic [31:0]   w_buf [MAX_NK];
  logic [31:0]   temp, w_old, sub_in, sub_out, temp_mod, word_new;
  logic          legal_start, stall, last_accept, gen, kill;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the AES affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] len);
    case (len)
      2'b00:   return 4'd4;
      2'b01:   return 4'd6;
      2'b10:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  assign nk_s        = nk_of(key_len);
  assign nr_s        = nk_s + 4'd6;
  assign legal_start = start && (state == IDLE) && (key_len != 2'b11) &&
                       (int'(nk_s) <= MAX_NK);
  assign stall       = rk_valid && !rk_ready;
  assign busy        = (state != IDLE);
  assign gen         = busy && !stall && (word_cnt != total_q);
`ifdef KEYEXP_ABORT_EN
  assign kill        = abort && busy;
`else
  assign kill        = 1'b0;
`endif
  assign last_accept = rk_valid && rk_ready && (rk_idx == RK_IDX_W'(nr_q));
  assign done        = last_accept && !kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (legal_start) state_nxt = EXPAND;
      EXPAND:  if (last_accept) state_nxt = IDLE;
               else if (stall)  state_nxt = HOLD;
      HOLD:    if (last_accept) state_nxt = IDLE;
               else if (rk_ready) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // w_buf[0] is w[i-1]; w_buf[nk-1] is w[i-nk].
  always_comb begin
    temp  = w_buf[0];
    w_old = w_buf[0];
    for (int j = 0; j < MAX_NK; j++)
      if (j == int'(nk_q) - 1) w_old = w_buf[j];
    sub_in  = (mod_cnt == 3'd0) ? {temp[23:0], temp[31:24]} : temp;
    sub_out = sub_word(sub_in);
    if (mod_cnt == 3'd0)                         temp_mod = sub_out ^ {rcon, 24'h0};
    else if (nk_q == 4'd8 && mod_cnt == 3'd4)    temp_mod = sub_out;
    else                                         temp_mod = temp;
    word_new = (word_cnt < {2'b00, nk_q}) ? key_q[255:224] : (w_old ^ temp_mod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= '0;
      nk_q      <= '0;
      nr_q      <= '0;
      total_q   <= '0;
      word_cnt  <= '0;
      mod_cnt   <= '0;
      rcon      <= 8'h01;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      round_key <= '0;
      // NOTE: the word history is a small register array, so it is reset like any other state.
      for (int j = 0; j < MAX_NK; j++) w_buf[j] <= '0;
    end else if (kill) begin
      word_cnt  <= '0;
      mod_cnt   <= '0;
      rcon      <= 8'h01;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      round_key <= '0;
      for (int j = 0; j < MAX_NK; j++) w_buf[j] <= '0;
    end else if (legal_start) begin
      key_q    <= key_in;
      nk_q     <= nk_s;
      nr_q     <= nr_s;
      total_q  <= {nr_s + 4'd1, 2'b00};
      word_cnt <= '0;
      mod_cnt  <= '0;
      rcon     <= 8'h01;
      rk_valid <= 1'b0;
    end else begin
      if (rk_valid && rk_ready) rk_valid <= 1'b0;
      if (gen) begin
        w_buf[0] <= word_new;
        for (int j = 1; j < MAX_NK; j++) w_buf[j] <= w_buf[j-1];
        key_q    <= {key_q[223:0], 32'h0};
        word_cnt <= word_cnt + 6'd1;
        mod_cnt  <= ({1'b0, mod_cnt} == nk_q - 4'd1) ? 3'd0 : mod_cnt + 3'd1;
        if (word_cnt >= {2'b00, nk_q} && mod_cnt == 3'd0) rcon <= xtime(rcon);
        // Fourth word of a group completes a round key.
        if (word_cnt[1:0] == 2'b11) begin
          round_key <= {w_buf[2], w_buf[1], w_buf[0], word_new};
          rk_valid  <= 1'b1;
          rk_idx    <= RK_IDX_W'(word_cnt[5:2]);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_expand_seq.sv
// Self-checking bench for key_expand_seq: known-answer vectors, stall, illegal/overlapping starts,
// mid-run reset and randomized keys/back-pressure against a table-driven key-schedule model.
module tb_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst_n, start, rk_ready, rk_valid, busy, done;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
`ifdef KEYEXP_ABORT_EN
  logic         abort = 1'b0;
`endif

  key_expand_seq #(.MAX_NK(8), .RK_IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_len(key_len), .key_in(key_in),
    .rk_ready(rk_ready),
`ifdef KEYEXP_ABORT_EN
    .abort(abort),
`endif
    .rk_valid(rk_valid), .rk_idx(rk_idx), .round_key(round_key), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int edge_count = 0, start_edge = 0;
  int n_accept = 0, acc_base = 0, n_done = 0, done_base = 0;
  int ready_mode = 0;              // 0: ready always high, 1: random, 2: 5-cycle stall at rk_idx 3
  bit mon_en = 1'b0;
  int exp_nr = 10;
  logic [127:0] exp_rk [15];
  logic [127:0] got_rk [15];
  logic [7:0]   sbox_t [256];
  logic [7:0]   rcon_tab [10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  // S-box built by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  endtask

  function automatic logic [31:0] sub32(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [1:0] len, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    int nk;
    nk     = 4 + 2 * int'(len);
    exp_nr = nk + 6;
    for (int i = 0; i < 4 * (exp_nr + 1); i++) begin
      if (i < nk) w[i] = key[255 - 32 * i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0)                 t = sub32({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
        else if (nk == 8 && i % nk == 4) t = sub32(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= exp_nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(posedge clk) edge_count++;

  // Back-pressure driver.
  initial begin
    int stall_left;
    stall_left = 5;
    rk_ready   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode != 2) stall_left = 5;
      case (ready_mode)
        1: rk_ready = ($urandom_range(0, 3) != 0);
        2: if (rk_valid && rk_idx == 4'd3 && stall_left > 0) begin
             rk_ready = 1'b0;
             stall_left--;
           end else rk_ready = 1'b1;
        default: rk_ready = 1'b1;
      endcase
    end
  end

  // Per-cycle compare against the model.
  int           mon_k, mon_idx;
  bit           prev_stall = 1'b0;
  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon_k   = edge_count - start_edge;
      mon_idx = n_accept - acc_base;
      if (prev_stall) begin
        check("stall_valid", rk_valid, 1'b1);
        check("stall_idx", rk_idx, prev_idx);
        check("stall_key", round_key, prev_key);
      end
      if (ready_mode == 0) begin
        check("valid_timing", rk_valid, (mon_k % 4 == 0) && mon_k >= 4 && mon_k <= 4 * (exp_nr + 1));
        check("busy_timing", busy, mon_k < 4 * (exp_nr + 1) + 1);
      end
      if (rk_valid) begin
        check("rk_idx", rk_idx, mon_idx);
        if (mon_idx <= exp_nr) check("round_key", round_key, exp_rk[mon_idx]);
      end
      check("done", done, rk_valid && rk_ready && (mon_idx == exp_nr));
      prev_stall = rk_valid && !rk_ready;
      prev_idx   = rk_idx;
      prev_key   = round_key;
      if (rk_valid && rk_ready) begin
        if (mon_idx >= 0 && mon_idx < 15) got_rk[mon_idx] = round_key;
        n_accept++;
      end
      if (done) n_done++;
    end else prev_stall = 1'b0;
  end

  // Caller is away from a clock edge; the start edge is the next rising edge.
  task automatic do_start(input logic [1:0] len, input logic [255:0] key);
    model_expand(len, key);
    acc_base  = n_accept;
    done_base = n_done;
    start     = 1'b1;
    key_len   = len;
    key_in    = key;
    @(posedge clk);
    #1;
    start      = 1'b0;
    start_edge = edge_count;
    key_in     = {8{$urandom}};
    key_len    = 2'($urandom_range(0, 3));
    mon_en     = 1'b1;
  endtask

  task automatic poke_start(input logic [1:0] len);
    start   = 1'b1;
    key_len = len;
    key_in  = {8{$urandom}};
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_edges);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("busy_timeout", busy, 1'b0);
    if (exp_edges > 0) check("busy_fall_edge", edge_count - start_edge, exp_edges);
    check("keys_delivered", n_accept - acc_base, exp_nr + 1);
    check("done_pulses", n_done - done_base, 1);
    mon_en = 1'b0;
  endtask

  localparam logic [127:0] K128_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K128_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [255:0] rkey;
    logic [1:0]   rlen;
    build_sbox();
    rst_n   = 1'b1;
    start   = 1'b0;
    key_len = 2'b00;
    key_in  = '0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_rk_valid", rk_valid, 1'b0);
    check("reset_rk_idx", rk_idx, 4'd0);
    check("reset_round_key", round_key, 128'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    start = 1'b1;                         // must not be latched during reset
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("no_start_in_reset", busy, 1'b0);

    // Illegal key length is ignored.
    poke_start(2'b11);
    check("illegal_len_busy", busy, 1'b0);
    check("illegal_len_valid", rk_valid, 1'b0);

    // AES-128 known answer, with an overlapping start that must be ignored.
    ready_mode = 0;
    do_start(2'b00, {K128_A, 128'h0});
    repeat (6) begin @(posedge clk); #1; end
    poke_start(2'b01);
    check("busy_start_ignored", busy, 1'b1);
    wait_done(45);
    check("model_aes128_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("aes128_rk0", got_rk[0], K128_A);
    check("aes128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192 started in the cycle right after busy fell.
    do_start(2'b01, {K192, 64'h0});
    wait_done(53);
    check("model_aes192_rk12", exp_rk[12], 128'he98ba06f448c773c8ecc720401002202);
    check("aes192_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

    do_start(2'b10, K256);
    wait_done(61);
    check("model_aes256_rk14", exp_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);
    check("aes256_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // Five-cycle stall on rk_idx 3.
    ready_mode = 2;
    do_start(2'b00, {K128_B, 128'h0});
    wait_done(50);
    check("model_fips_c1_rk10", exp_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("stall_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset in the middle of an expansion.
    ready_mode = 0;
    do_start(2'b10, K256);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rk_valid && rk_idx == 4'd5) break;
    end
    check("reach_idx5", rk_idx, 4'd5);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rk_valid", rk_valid, 1'b0);
    check("midrst_rk_idx", rk_idx, 4'd0);
    check("midrst_round_key", round_key, 128'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_idle", busy, 1'b0);
    rkey = {{4{$urandom}}, 128'h0};
    do_start(2'b00, rkey);
    wait_done(45);
    check("after_rst_rk0", got_rk[0], rkey[255:128]);

    // Randomized keys and back-pressure.
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      rlen = 2'($urandom_range(0, 2));
      rkey = {8{$urandom}};
      do_start(rlen, rkey);
      wait_done(0);
      check("rand_rk0", got_rk[0], rkey[255:128]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, maximum key words held in the history buffer (legal values 4, 6, 8).
REQ-002 SHALL have parameter RK_IDX_W, default 4, width of the round-key index output.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request that begins an expansion.
REQ-006 SHALL have port key_len, input, 2, key-length select: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
REQ-007 SHALL have port key_in, input, 256, MSB-aligned cipher key; word 0 = key_in[255:224], unused LSBs ignored.
REQ-008 SHALL have port rk_ready, input, 1, consumer accepts the current round key.
REQ-009 SHALL have port rk_valid, output, 1, round_key/rk_idx valid.
REQ-010 SHALL have port rk_idx, output, RK_IDX_W, round number r of the presented key.
REQ-011 SHALL have port round_key, output, 128, round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].
REQ-012 SHALL have port busy, output, 1, expansion in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse coinciding with acceptance of the final round key.

Function
REQ-014 SHALL implement states IDLE, EXPAND, HOLD.
- IDLE -> EXPAND on start with a legal key_len.
- EXPAND -> HOLD when rk_valid && !rk_ready.
- HOLD -> EXPAND on rk_ready.
- Exit to IDLE when the last key is accepted.
REQ-015 SHALL capture key_in and key_len on the start edge; later input changes have no effect until the next start.
REQ-016 SHALL set Nk = 4/6/8 and Nr = 10/12/14 from key_len; total words = 4(Nr+1), i.e. 44/52/60.
REQ-017 SHALL generate exactly one 32-bit word per EXPAND cycle; word i is produced on edge i+1 after the start edge.
REQ-018 SHALL take words i < Nk directly from the captured key.
REQ-019 SHALL compute words i >= Nk as w[i] = w[i-Nk] ^ temp, where temp = w[i-1], modified as follows:
- i mod Nk == 0: SubWord(RotWord(temp)) ^ {Rcon[i/Nk], 24'h0}.
- Nk == 8 and i mod 8 == 4: SubWord(temp).
REQ-020 SHALL generate Rcon sequentially: 01, doubling in GF(2^8) with reduction polynomial 0x11B (01, 02, ... 80, 1B, 36).
REQ-021 SHALL keep the last MAX_NK words in a shift buffer; no full expanded-key storage.
REQ-022 SHALL assert rk_valid in the cycle following production of word 4r+3, with rk_idx = r.
REQ-023 SHALL, while rk_valid && !rk_ready, freeze word generation and hold round_key, rk_idx and rk_valid stable.
REQ-024 SHALL pulse done for the single cycle in which rk_valid && rk_ready && rk_idx == Nr; busy deasserts on the following edge.
REQ-025 SHALL ignore start while busy, and ignore start with key_len == 11 (no state change).
REQ-026 SHALL, with rk_ready held high throughout, produce all Nr+1 keys back-to-back with rk_valid asserted on every fourth cycle, and deassert busy 4(Nr+1)+1 edges after start.
REQ-027 SHALL accept a start in the cycle after busy falls.

Reset
REQ-028 SHALL, on rst_n low at any time (including mid-expansion or in HOLD), immediately clear to IDLE with rk_valid = 0, rk_idx = 0, round_key = 0, busy = 0, done = 0, the word buffer cleared and Rcon = 01.
REQ-029 SHALL begin operating on the first rising clk edge after rst_n deasserts; no start is latched during reset.

Configuration
REQ-030 SHALL, when KEYEXP_ABORT_EN is defined, add input port abort (1 bit). abort high while busy returns the block to IDLE on the next edge with reset-equivalent outputs and no done pulse; abort while idle has no effect.
REQ-031 SHALL, when KEYEXP_ABORT_EN is not defined, have no abort port; an expansion is terminated only by rst_n.

Verification
REQ-032 SHALL cover: AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1 -> rk_idx 0 = the key, rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done with idx 10.
REQ-033 SHALL cover: AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 keys, rk_idx 12 = e98ba06f448c773c8ecc720401002202.
REQ-034 SHALL cover: AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx 14 = fe4890d1e6188d0b046df344706c631e.
REQ-035 SHALL cover: AES-128, key 000102030405060708090a0b0c0d0e0f, rk_ready low for 5 cycles at rk_idx 3 -> outputs stable during the stall, rk_idx 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-036 SHALL cover: start with key_len = 11, plus a second start during busy -> no state change from either; the first expansion completes correctly.
REQ-037 SHALL cover: rst_n pulsed low at rk_idx 5 -> all outputs 0 immediately; a new start then yields correct keys from rk_idx 0.
